// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the MIPS pipeline hazard sequencer: FSM encoding,
// scoreboard entry layout and register/instruction constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    FLUSH     = 2'd2,
    RAW_STALL = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rg;
  } sb_entry_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination register tracker (EX, MEM, WB) with dual source compare.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 3,
  parameter bit WB_SPLIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       kill0,
  input  sb_entry_t  push,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hit_rs,
  output logic       hit_rt
);

  // The WB slot writes before the read half-cycle, so it can be masked off.
  localparam int CMP_N = WB_SPLIT ? SB_DEPTH - 1 : SB_DEPTH;

  sb_entry_t [SB_DEPTH-1:0] sb;
  sb_entry_t                e0_kept;
  logic      [SB_DEPTH-1:0] m_rs, m_rt;

  always_comb begin
    e0_kept       = sb[0];
    e0_kept.valid = sb[0].valid & ~kill0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (shift_en) begin
      sb[0] <= push;
      for (int i = 1; i < SB_DEPTH; i++)
        sb[i] <= (i == 1) ? e0_kept : sb[i-1];
    end else if (kill0) begin
      sb[0].valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_cmp
    if (i < CMP_N) begin : g_live
      assign m_rs[i] = sb[i].valid & (sb[i].rg == rs);
      assign m_rt[i] = sb[i].valid & (sb[i].rg == rt);
    end else begin : g_mask
      assign m_rs[i] = 1'b0;
      assign m_rt[i] = 1'b0;
    end
  end

  assign hit_rs = |m_rs;
  assign hit_rt = |m_rt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW stall, redirect flush and memory freeze control
// for a 5-stage MIPS core without forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH     = 3,
  parameter bit WB_SPLIT     = 1'b1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic             id_rs_used,
  input  logic [4:0]       id_rt,
  input  logic             id_rt_used,
  input  logic [4:0]       id_wreg,
  input  logic             id_regwrite,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_kill,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t          state, resume, eff;
  logic            redir_pend, redir_eff, mem_busy, raw, hit_rs, hit_rt;
  logic [FC_W-1:0] fcnt;
  sb_entry_t       push;

  assign mem_busy  = mem_req & ~mem_ready;
  assign redir_eff = redirect | redir_pend;
  // While frozen, decisions resume from the state held before the freeze.
  assign eff       = (state == MEM_WAIT) ? resume : state;
  assign raw       = id_valid & ((id_rs_used & (id_rs != REG_ZERO) & hit_rs) |
                                 (id_rt_used & (id_rt != REG_ZERO) & hit_rt));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_kill     = 1'b0;
    pipe_en     = 1'b0;
    if (rst_n && !mem_busy) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      pipe_en = 1'b1;
      if (redir_eff || eff == FLUSH) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        ex_kill     = redir_eff;
      end else if (raw) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    push.valid = id_valid & id_regwrite & (id_wreg != REG_ZERO) & ~idex_bubble;
    push.rg    = id_wreg;
  end

  hazard_scoreboard #(.SB_DEPTH(SB_DEPTH), .WB_SPLIT(WB_SPLIT)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (pipe_en),
    .kill0    (redir_eff & ~mem_busy),
    .push     (push),
    .rs       (id_rs),
    .rt       (id_rt),
    .hit_rs   (hit_rs),
    .hit_rt   (hit_rt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      resume       <= RUN;
      redir_pend   <= 1'b0;
      fcnt         <= '0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (mem_busy) begin
        state <= MEM_WAIT;
        if (state != MEM_WAIT) resume <= state;
        if (redirect) redir_pend <= 1'b1;
      end else if (redir_eff) begin
        redir_pend <= 1'b0;
        fcnt       <= FC_W'(FLUSH_CYCLES - 1);
        state      <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (eff == FLUSH) begin
        fcnt  <= fcnt - FC_W'(1);
        state <= (fcnt == FC_W'(1)) ? RUN : FLUSH;
      end else if (raw) begin
        state <= RAW_STALL;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule
